fire6_expand3_ofm_writer: RTL and testbench

// - Consumer end of the fire6_expand3 sample interface. On each sample pulse it captures the
//   DSP_NO-wide ofm vector and serialises it, one word per cycle, into the output feature-map
//   RAM write port.
// - Counts WOUT**2 output pixels; after the last RAM write it pulses ram_feedback back to the

---
 rtl/fire_pkg.sv | 24 ++
 rtl/fire6_expand3_ofm_writer_if.sv | 27 ++
 rtl/fire_ofm_pingpong.sv | 63 ++++++
 rtl/fire6_expand3_ofm_writer.sv | 162 ++++++++++++++++
 tb/tb_fire6_expand3_ofm_writer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared types, constants and address helper for the fire6 expand3 ofm writer
package fire_pkg;

   localparam int FIRE_WIDTH  = 16;
   localparam int FIRE_DSP_NO = 256;
   localparam int FIRE_WOUT   = 16;
   localparam int PIX_TOTAL   = FIRE_WOUT ** 2;

   typedef logic [FIRE_WIDTH-1:0] act_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } ofmw_state_t;

   // Channel-major layout: every channel owns a contiguous plane of pix_total words.
   function automatic int unsigned ofm_addr(input int unsigned ch,
                                            input int unsigned pix,
                                            input int unsigned pix_total);
      return ch * pix_total + pix;
   endfunction

endpackage

// File: rtl/fire6_expand3_ofm_writer_if.sv
// rtl/fire6_expand3_ofm_writer_if.sv - layer sample input and output feature-map RAM write port
interface fire6_expand3_ofm_writer_if #(
   parameter int WIDTH  = 16,
   parameter int DSP_NO = 256,
   parameter int AW     = 16
);
   logic             sample_in;
   logic [WIDTH-1:0] ofm_in [DSP_NO];
   logic             ram_ready;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_wdata;
   logic             ram_feedback;
   logic             done;
   logic             busy;
   logic             err;

   modport master (
      output sample_in, ofm_in, ram_ready,
      input  ram_we, ram_addr, ram_wdata, ram_feedback, done, busy, err
   );

   modport slave (
      input  sample_in, ofm_in, ram_ready,
      output ram_we, ram_addr, ram_wdata, ram_feedback, done, busy, err
   );
endinterface

// File: rtl/fire_ofm_pingpong.sv
// rtl/fire_ofm_pingpong.sv - two-bank sample store with valid bits, bank pointers and registered word read
module fire_ofm_pingpong
   import fire_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DSP_NO = 256,
   parameter int CW     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic [WIDTH-1:0] cap_data [DSP_NO],
   input  logic             drain_done,
   input  logic             rd_load,
   input  logic             rd_sel,
   input  logic [CW-1:0]    rd_idx,
   output logic [1:0]       valid,
   output logic             wr_bank,
   output logic             rd_bank,
   output logic [WIDTH-1:0] rd_word
);
   logic [WIDTH-1:0] mem [2][DSP_NO];

   // Capture and drain-complete always target different banks, so both may land on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (capture) begin
            valid[wr_bank] <= 1'b1;
            wr_bank        <= ~wr_bank;
         end
         if (drain_done) begin
            valid[rd_bank] <= 1'b0;
            rd_bank        <= ~rd_bank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < DSP_NO; i++) begin
            mem[wr_bank][i] <= cap_data[i];
         end
      end
   end

   // A bank being filled on this edge is read straight from the input vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_word <= '0;
      end else if (rd_load) begin
         if (capture && (wr_bank == rd_sel)) begin
            rd_word <= cap_data[rd_idx];
         end else begin
            rd_word <= mem[rd_sel][rd_idx];
         end
      end
   end

endmodule

// File: rtl/fire6_expand3_ofm_writer.sv
// rtl/fire6_expand3_ofm_writer.sv - serialises captured ofm vectors into the ofm RAM, one word per cycle
// Optional sticky overflow flag on err is built when FIRE6_OFMW_OVF_CHECK_EN is defined.
module fire6_expand3_ofm_writer
   import fire_pkg::*;
#(
   parameter int WIDTH  = FIRE_WIDTH,
   parameter int DSP_NO = FIRE_DSP_NO,
   parameter int WOUT   = FIRE_WOUT,
   parameter int AW     = $clog2(DSP_NO * WOUT * WOUT)
) (
   input logic                        clk,
   input logic                        rst,
   fire6_expand3_ofm_writer_if.slave  bus
);
   localparam int NPIX = WOUT * WOUT;
   localparam int CW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
   localparam int PW   = $clog2(NPIX + 1);

   ofmw_state_t      state;
   logic [CW-1:0]    ch;
   logic [PW-1:0]    pix;
   logic             ram_we_r;
   logic [AW-1:0]    addr_r;
   logic             fb_r;
   logic             done_r;
   logic [WIDTH-1:0] word;
   logic [1:0]       valid;
   logic             wr_bank;
   logic             rd_bank;

   logic             cap;
   logic             commit;
   logic             last_ch;
   logic             drain_done;
   logic             layer_end;
   logic             cur_avail;
   logic             nxt_avail;
   logic [PW-1:0]    pix_inc;
   logic             ld;
   logic             ld_sel;
   logic [CW-1:0]    ld_ch;
   logic [PW-1:0]    ld_pix;

   // ld/ld_* describe the word that will be presented on the RAM port after this edge.
   always_comb begin
      cap        = bus.sample_in && !valid[wr_bank] && !done_r && (pix < PW'(NPIX));
      commit     = (state == DRAIN) && bus.ram_ready;
      last_ch    = (ch == CW'(DSP_NO - 1));
      drain_done = commit && last_ch;
      pix_inc    = pix + PW'(1);
      layer_end  = (pix_inc == PW'(NPIX));
      cur_avail  = valid[rd_bank] || (cap && (wr_bank == rd_bank));
      nxt_avail  = valid[~rd_bank] || (cap && (wr_bank != rd_bank));
      ld         = 1'b0;
      ld_sel     = rd_bank;
      ld_ch      = '0;
      ld_pix     = pix;
      if ((state == IDLE) && cur_avail) begin
         ld = 1'b1;
      end else if (commit && !last_ch) begin
         ld    = 1'b1;
         ld_ch = ch + CW'(1);
      end else if (drain_done && !layer_end && nxt_avail) begin
         ld     = 1'b1;
         ld_pix = pix_inc;
         ld_sel = ~rd_bank;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ch       <= '0;
         pix      <= '0;
         ram_we_r <= 1'b0;
         addr_r   <= '0;
         fb_r     <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         fb_r <= 1'b0;
         if (ld) begin
            addr_r <= AW'(ofm_addr(32'(ld_ch), 32'(ld_pix), 32'(NPIX)));
         end
         case (state)
            IDLE: begin
               if (cur_avail) begin
                  state    <= DRAIN;
                  ram_we_r <= 1'b1;
               end
            end
            DRAIN: begin
               if (commit) begin
                  if (last_ch) begin
                     ch  <= '0;
                     pix <= pix_inc;
                     if (layer_end) begin
                        state    <= DONE;
                        ram_we_r <= 1'b0;
                        fb_r     <= 1'b1;
                        done_r   <= 1'b1;
                     end else if (!nxt_avail) begin
                        state    <= IDLE;
                        ram_we_r <= 1'b0;
                     end
                  end else begin
                     ch <= ch + CW'(1);
                  end
               end
            end
            DONE: begin
            end
            default: begin
               state    <= IDLE;
               ram_we_r <= 1'b0;
            end
         endcase
      end
   end

   fire_ofm_pingpong #(
      .WIDTH  (WIDTH),
      .DSP_NO (DSP_NO),
      .CW     (CW)
   ) u_pingpong (
      .clk        (clk),
      .rst        (rst),
      .capture    (cap),
      .cap_data   (bus.ofm_in),
      .drain_done (drain_done),
      .rd_load    (ld),
      .rd_sel     (ld_sel),
      .rd_idx     (ld_ch),
      .valid      (valid),
      .wr_bank    (wr_bank),
      .rd_bank    (rd_bank),
      .rd_word    (word)
   );

`ifdef FIRE6_OFMW_OVF_CHECK_EN
   logic err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (bus.sample_in && (&valid)) begin
         err_r <= 1'b1;
      end
   end

   assign bus.err = err_r;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.ram_we       = ram_we_r;
   assign bus.ram_addr     = addr_r;
   assign bus.ram_wdata    = word;
   assign bus.ram_feedback = fb_r;
   assign bus.done         = done_r;
   assign bus.busy         = (|valid) || (state == DRAIN);

endmodule

// File: tb/tb_fire6_expand3_ofm_writer.sv
// tb/tb_fire6_expand3_ofm_writer.sv - self-checking bench for fire6_expand3_ofm_writer (reduced geometry)
module tb_fire6_expand3_ofm_writer;
   import fire_pkg::*;

   localparam int WIDTH  = 16;
   localparam int DSP_NO = 16;
   localparam int WOUT   = 4;
   localparam int NPIX   = WOUT * WOUT;
   localparam int AW     = $clog2(DSP_NO * NPIX);
   localparam int PERIOD = 3 * DSP_NO;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fire6_expand3_ofm_writer_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .AW(AW)) bus ();

   fire6_expand3_ofm_writer #(
      .WIDTH  (WIDTH),
      .DSP_NO (DSP_NO),
      .WOUT   (WOUT),
      .AW     (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;
   wr_t expq[$];
   int  commit_cyc[$];
   int  accepted = 0;
   int  commits  = 0;
   int  dropped  = 0;
   int  fb_cnt   = 0;
   int  fb_cyc   = -1;
   int  ready_mode = 0;
   logic             hold_valid = 1'b0;
   logic [AW-1:0]    hold_addr  = '0;
   logic [WIDTH-1:0] hold_data  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_err();
`ifdef FIRE6_OFMW_OVF_CHECK_EN
      return (dropped > 0) ? 32'd1 : 32'd0;
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference: a sample is taken when fewer than two pixels are pending and the layer is unfinished;
   // pixel k of the layer produces DSP_NO writes at ch*NPIX+k in channel order.
   task automatic send_sample();
      act_t v [DSP_NO];
      int   pend;
      for (int i = 0; i < DSP_NO; i++) v[i] = act_t'($urandom);
      pend = accepted - commits / DSP_NO;
      if (pend < 2 && commits < DSP_NO * NPIX) begin
         if (accepted < NPIX) begin
            for (int c = 0; c < DSP_NO; c++) expq.push_back('{addr: AW'(c * NPIX + accepted), data: v[c]});
         end
         accepted++;
      end else if (pend >= 2) begin
         dropped++;
      end
      bus.ofm_in    = v;
      bus.sample_in = 1'b1;
      tick();
      bus.sample_in = 1'b0;
      for (int i = 0; i < DSP_NO; i++) bus.ofm_in[i] = act_t'($urandom);
   endtask

   task automatic flush_model();
      expq.delete();
      commit_cyc.delete();
      accepted = 0;
      commits  = 0;
      dropped  = 0;
      fb_cnt   = 0;
      fb_cyc   = -1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((bus.busy || expq.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
      check({tag, "_all_written"}, 32'(expq.size()), 32'd0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       bus.ram_ready = 1'b1;
         1:       bus.ram_ready = ~bus.ram_ready;
         2:       bus.ram_ready = ($urandom_range(0, 3) != 0);
         default: bus.ram_ready = 1'b0;
      endcase
   end

   // Write monitor: every committed word must match the head of the expected queue,
   // and a stalled word must stay on the port unchanged.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) begin
            check("stall_we_held", 32'(bus.ram_we), 32'd1);
            check("stall_addr_held", 32'(bus.ram_addr), 32'(hold_addr));
            check("stall_data_held", 32'(bus.ram_wdata), 32'(hold_data));
         end
         hold_valid = bus.ram_we && !bus.ram_ready;
         hold_addr  = bus.ram_addr;
         hold_data  = bus.ram_wdata;
         if (bus.ram_we && bus.ram_ready) begin
            check("write_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               wr_t e;
               e = expq.pop_front();
               check("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
               check("wr_data", 32'(bus.ram_wdata), 32'(e.data));
            end
            commits++;
            commit_cyc.push_back(cyc);
         end
         if (bus.ram_feedback) begin
            fb_cnt++;
            fb_cyc = cyc;
         end
      end
   end

   initial begin
      int n0;
      int target;
      int n;
      bus.sample_in = 1'b0;
      bus.ram_ready = 1'b1;
      for (int i = 0; i < DSP_NO; i++) bus.ofm_in[i] = '0;

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_we", 32'(bus.ram_we), 32'd0);
      check("rst_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
      check("rst_feedback", 32'(bus.ram_feedback), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(2);

      // single sample at full ready; first write one cycle after the sample
      ready_mode = 0;
      tick(2);
      check("idle_we", 32'(bus.ram_we), 32'd0);
      send_sample();
      check("first_we_latency", 32'(bus.ram_we), 32'd1);
      check("first_addr", 32'(bus.ram_addr), 32'd0);
      wait_idle("single");

      // reset in the middle of a drain abandons the pixel
      send_sample();
      target = commits + DSP_NO / 2;
      n = 0;
      while (commits < target && n < 200) begin
         tick();
         n++;
      end
      check("mid_drain_reached", 32'(commits >= target), 32'd1);
      rst = 1'b1;
      flush_model();
      @(negedge clk);
      check("midrst_we", 32'(bus.ram_we), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_addr", 32'(bus.ram_addr), 32'd0);
      tick();
      rst = 1'b0;
      tick(2);
      send_sample();
      wait_idle("after_rst");

      // backpressure: ready toggling
      ready_mode = 1;
      n0 = commits;
      send_sample();
      wait_idle("backpressure");
      check("bp_commit_count", 32'(commits - n0), 32'(DSP_NO));

      // back-to-back samples: second drain follows with no idle gap
      ready_mode = 0;
      tick(2);
      n0 = commit_cyc.size();
      send_sample();
      tick(9);
      send_sample();
      wait_idle("b2b");
      check("b2b_commit_count", 32'(commit_cyc.size() - n0), 32'(2 * DSP_NO));
      if (commit_cyc.size() >= n0 + 2 * DSP_NO)
         check("b2b_no_gap", 32'(commit_cyc[n0 + 2 * DSP_NO - 1] - commit_cyc[n0]), 32'(2 * DSP_NO - 1));

      // overflow: three samples with RAM stalled, third is dropped
      ready_mode = 3;
      tick(2);
      send_sample();
      tick(2);
      send_sample();
      tick(2);
      send_sample();
      tick(2);
      check("ovf_busy", 32'(bus.busy), 32'd1);
      check("ovf_we_stalled", 32'(bus.ram_we), 32'd1);
      check("ovf_err", 32'(bus.err), exp_err());
      ready_mode = 0;
      wait_idle("ovf");
      check("ovf_err_sticky", 32'(bus.err), exp_err());

      // random spacing with random ready
      ready_mode = 2;
      for (int k = 0; k < 6; k++) begin
         send_sample();
         tick($urandom_range(0, 30));
      end
      wait_idle("random");
      check("random_err", 32'(bus.err), exp_err());
      check("random_not_done", 32'(bus.done), 32'd0);

      // full layer from a fresh reset: NPIX+1 samples, the extra one ignored
      @(posedge clk);
      #1 rst = 1'b1;
      flush_model();
      tick(2);
      rst = 1'b0;
      tick(2);
      check("layer_start_err", 32'(bus.err), 32'd0);
      ready_mode = 2;
      for (int s = 0; s < NPIX; s++) begin
         send_sample();
         tick(PERIOD - 1);
      end
      n = 0;
      while (!bus.done && n < 2000) begin
         tick();
         n++;
      end
      tick(2);
      check("layer_done", 32'(bus.done), 32'd1);
      check("layer_commits", 32'(commits), 32'(DSP_NO * NPIX));
      check("layer_feedback_pulses", 32'(fb_cnt), 32'd1);
      if (commit_cyc.size() != 0)
         check("layer_feedback_after_last", 32'(fb_cyc), 32'(commit_cyc[commit_cyc.size() - 1] + 1));
      check("layer_queue_empty", 32'(expq.size()), 32'd0);
      n0 = commits;
      send_sample();
      tick(PERIOD);
      check("extra_sample_ignored", 32'(commits - n0), 32'd0);
      check("extra_busy", 32'(bus.busy), 32'd0);
      check("extra_done_held", 32'(bus.done), 32'd1);
      check("extra_feedback_low", 32'(bus.ram_feedback), 32'd0);
      check("extra_feedback_count", 32'(fb_cnt), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
